arinc_recv: RTL and testbench
=============================

// Module: arinc_recv
// PURPOSE
//  Receive end of the two-board ARINC429-style link. Decodes the bipolar return-to-zero
//  pair RxA/RxB into 24-bit words, sent LSB first, and validates symbol widths and inter-word gaps.
//  Presents each good word with a one-cycle valid pulse. Sits at the board input pins,
//  opposite the send transmitter, and runs on the same system clock.
// PARAMETERS
//  HALF_H  502      clk cycles per half-bit at high rate (one tx state period)
//  HALF_L  5020502  clk cycles per half-bit at low rate
//  GAP_HB  4        null length, in half-bits, that ends a word (tx gap is >=7)
//  FILT    8        clk cycles a symbol must be stable before it is accepted
//  CNT_W   25       timer width; must hold GAP_HB*HALF_L
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   asynchronous active-low reset
//  RxA            in   1   line A, async to clk
//  RxB            in   1   line B, async to clk
//  recv_rate_sel  in   1   1=high rate (HALF_H), 0=low rate (HALF_L)
//  dat24          out  24  last good word; bit0 = first bit received
//  valid          out  1   one-cycle pulse; dat24 updated in the same cycle
//  err            out  1   one-cycle pulse on any protocol violation
//  err_code       out  2   01 both-high, 10 bit-count, 11 width; held until next err
//  busy           out  1   1 from first data symbol until word end or error
// BEHAVIOUR
//  - One clock, clk. Reset is asynchronous and active-low (rst_n). Reset clears every
//    output to 0, clears the shift register and bit count, and enters WAIT_GAP.
//  - Input path: 2-flop synchroniser per line, then FILT-cycle stability filter.
//    Filtered pair decodes to symbol ONE(A=1,B=0), ZERO(0,1), NULL(0,0), BOTH(1,1).
//  - Rate (HALF = HALF_H or HALF_L) is sampled on entry to DATA from IDLE and held for
//    the whole word. Changes to recv_rate_sel mid-word are ignored.
//  - Timer: cleared on every symbol change and saturates at its maximum value.
//  - FSM:
//    WAIT_GAP: NULL for timer>=GAP_HB*HALF -> IDLE. Any other symbol restarts the timer.
//      This is the power-up and post-error resync state. No partial words are accepted.
//    IDLE: ONE/ZERO -> DATA, busy=1, shift in the bit, count=1. BOTH -> error 01.
//    DATA: NULL with timer in [HALF/2, 2*HALF] -> NULL. NULL with timer outside that
//      window -> error 11. Timer>2*HALF while still in DATA -> error 11. A direct
//      ONE<->ZERO change with no NULL between -> error 11. BOTH -> error 01.
//    NULL: ONE/ZERO with count<24 -> DATA, shift, count+1. ONE/ZERO with count==24
//      -> error 10. BOTH -> error 01. Timer>=GAP_HB*HALF: if count==24, dat24<=shift
//      register and valid=1; otherwise error 10. Either way busy=0 and go to IDLE.
//  - Shift: sr <= {bit, sr[23:1]}. After 24 bits, sr[0] is the first received bit.
//  - Error action: err=1 for one cycle, err_code updated, busy=0, count=0, -> WAIT_GAP.
//    dat24 is untouched on error.
//  - Latency: valid asserts on the cycle the gap threshold is reached, i.e.
//    GAP_HB*HALF + FILT + 2 clk after the last null begins on the pins.
//  - valid and err are never asserted in the same cycle.
// STRUCTURE
//  - Package arinc_pkg holds:
//    - FSM state encoding (WAIT_GAP, IDLE, DATA, NULL);
//    - symbol codes;
//    - err_code constants;
//    - default HALF_H/HALF_L, shared with send.
//  - Sub-module arinc_line_filter: synchroniser, FILT filter and symbol decode.
//    Outputs a 2-bit symbol and a one-cycle change strobe.
//  - arinc_recv holds the FSM, timer, bit counter, shift register and output registers.
// TESTING
//  - Drive the send model at high rate with 24'hA5C3F0, after the initial gap ->
//    one valid pulse, dat24==24'hA5C3F0, err never asserted.
//  - Send two back-to-back words 24'h000001 then 24'hFFFFFE with a 7-half-bit gap ->
//    two valid pulses in order, with matching dat24 values.
//  - Run at low rate with 24'h123456 and recv_rate_sel=0; toggle recv_rate_sel
//    mid-word -> dat24==24'h123456, no err.
//  - Send only 23 bits followed by the gap -> err with err_code=10, no valid.
//    The next full word is received normally.
//  - Assert RxA=RxB=1 for 20 clk mid-word -> err with err_code=01, busy=0.
//    The word that follows a clean gap decodes correctly.
//  - Stretch one data half-bit to 3*HALF_H -> err_code=11. Pulse rst_n low
//    mid-word -> all outputs 0 immediately, and a full gap is needed before accepting.

Source files
------------

// File: rtl/arinc_pkg.sv
`default_nettype none
// =====================================================================
// arinc_pkg : shared states, symbol codes and rates for the ARINC link
// Rev 1.0
// =====================================================================
package arinc_pkg;

  localparam int unsigned c_half_h    = 502;
  localparam int unsigned c_half_l    = 5020502;
  localparam int unsigned c_word_bits = 24;

  typedef enum logic [1:0] {
    ST_WAIT_GAP = 2'd0,
    ST_IDLE     = 2'd1,
    ST_DATA     = 2'd2,
    ST_NULL     = 2'd3
  } state_t;

  // Encoded as {A, B}
  typedef enum logic [1:0] {
    SYM_NULL = 2'b00,
    SYM_ZERO = 2'b01,
    SYM_ONE  = 2'b10,
    SYM_BOTH = 2'b11
  } sym_t;

  localparam logic [1:0] c_err_both  = 2'b01;
  localparam logic [1:0] c_err_count = 2'b10;
  localparam logic [1:0] c_err_width = 2'b11;

endpackage
`default_nettype wire

// File: rtl/arinc_line_filter.sv
`default_nettype none
// =====================================================================
// arinc_line_filter : RxA/RxB synchroniser, stability filter, decode
// Rev 1.0
// =====================================================================
module arinc_line_filter
  import arinc_pkg::*;
#(
  parameter int FILT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic RxA,
  input  logic RxB,
  output sym_t sym,
  output logic sym_chg
);

  localparam int c_cw = $clog2(FILT + 1);

  logic [1:0]      r_meta;
  logic [1:0]      r_sync;
  logic [1:0]      r_cand;
  logic [c_cw-1:0] r_cnt;
  sym_t            r_sym;
  logic            r_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 2'b00;
      r_sync <= 2'b00;
      r_cand <= 2'b00;
      r_cnt  <= '0;
      r_sym  <= SYM_NULL;
      r_chg  <= 1'b0;
    end else begin
      r_meta <= {RxA, RxB};
      r_sync <= r_meta;
      r_chg  <= 1'b0;
      // A candidate pair must hold FILT cycles before it replaces the symbol
      if (r_sync != r_cand) begin
        r_cand <= r_sync;
        r_cnt  <= '0;
      end else if (r_cnt != c_cw'(FILT - 1)) begin
        r_cnt <= r_cnt + c_cw'(1);
      end else if (r_cand != r_sym) begin
        r_sym <= sym_t'(r_cand);
        r_chg <= 1'b1;
      end
    end
  end

  assign sym     = r_sym;
  assign sym_chg = r_chg;

endmodule
`default_nettype wire

// File: rtl/arinc_recv.sv
`default_nettype none
// =====================================================================
// arinc_recv : ARINC429-style bipolar RZ receiver, 24-bit words
// Rev 1.0
// =====================================================================
module arinc_recv
  import arinc_pkg::*;
#(
  parameter int unsigned HALF_H = c_half_h,
  parameter int unsigned HALF_L = c_half_l,
  parameter int unsigned GAP_HB = 4,
  parameter int unsigned FILT   = 8,
  parameter int unsigned CNT_W  = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RxA,
  input  logic        RxB,
  input  logic        recv_rate_sel,
  output logic [23:0] dat24,
  output logic        valid,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        busy
);

  sym_t w_sym;
  logic w_chg;

  arinc_line_filter #(.FILT(FILT)) u_filt (
    .clk     (clk),
    .rst_n   (rst_n),
    .RxA     (RxA),
    .RxB     (RxB),
    .sym     (w_sym),
    .sym_chg (w_chg)
  );

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_timer, r_half;
  logic [CNT_W-1:0] w_half_live, w_half, w_gap_thr, w_win_lo, w_win_hi;
  logic [4:0]       r_count;
  logic [23:0]      r_sr;
  logic             w_shift, w_valid, w_err, w_load_half, w_end_word;
  logic [1:0]       w_err_code;
  logic             w_is_bit, w_gap_done, w_full;

  assign w_half_live = recv_rate_sel ? CNT_W'(HALF_H) : CNT_W'(HALF_L);
  // Rate is frozen for the duration of a word
  assign w_half      = (r_state == ST_DATA || r_state == ST_NULL) ? r_half : w_half_live;
  assign w_gap_thr   = w_half * CNT_W'(GAP_HB);
  assign w_win_lo    = w_half >> 1;
  assign w_win_hi    = w_half << 1;
  assign w_is_bit    = (w_sym == SYM_ONE) || (w_sym == SYM_ZERO);
  assign w_gap_done  = !w_chg && (w_sym == SYM_NULL) && (r_timer >= w_gap_thr);
  assign w_full      = (r_count == 5'(c_word_bits));

  always_comb begin
    w_state_nx  = r_state;
    w_shift     = 1'b0;
    w_valid     = 1'b0;
    w_err       = 1'b0;
    w_err_code  = 2'b00;
    w_load_half = 1'b0;
    w_end_word  = 1'b0;
    case (r_state)
      ST_WAIT_GAP: begin
        if (w_gap_done) w_state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        if (w_chg && w_is_bit) begin
          w_state_nx  = ST_DATA;
          w_shift     = 1'b1;
          w_load_half = 1'b1;
        end else if (w_chg && w_sym == SYM_BOTH) begin
          w_err      = 1'b1;
          w_err_code = c_err_both;
          w_state_nx = ST_WAIT_GAP;
        end
      end
      ST_DATA: begin
        if (w_chg) begin
          w_state_nx = ST_WAIT_GAP;
          w_err      = 1'b1;
          if (w_sym == SYM_BOTH) begin
            w_err_code = c_err_both;
          end else if (w_sym == SYM_NULL && r_timer >= w_win_lo && r_timer <= w_win_hi) begin
            w_err      = 1'b0;
            w_state_nx = ST_NULL;
          end else begin
            w_err_code = c_err_width;
          end
        end else if (r_timer > w_win_hi) begin
          w_err      = 1'b1;
          w_err_code = c_err_width;
          w_state_nx = ST_WAIT_GAP;
        end
      end
      ST_NULL: begin
        if (w_chg && w_is_bit) begin
          if (w_full) begin
            w_err      = 1'b1;
            w_err_code = c_err_count;
            w_state_nx = ST_WAIT_GAP;
          end else begin
            w_shift    = 1'b1;
            w_state_nx = ST_DATA;
          end
        end else if (w_chg && w_sym == SYM_BOTH) begin
          w_err      = 1'b1;
          w_err_code = c_err_both;
          w_state_nx = ST_WAIT_GAP;
        end else if (w_gap_done) begin
          // The gap itself already resynchronised the line, so return to IDLE
          w_end_word = 1'b1;
          w_state_nx = ST_IDLE;
          if (w_full) begin
            w_valid = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_err_code = c_err_count;
          end
        end
      end
      default: w_state_nx = ST_WAIT_GAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_WAIT_GAP;
      r_timer  <= '0;
      r_half   <= '0;
      r_count  <= '0;
      r_sr     <= '0;
      dat24    <= '0;
      valid    <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      busy     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_chg ? '0 : ((&r_timer) ? r_timer : r_timer + CNT_W'(1));
      valid   <= w_valid;
      err     <= w_err;
      if (w_load_half) r_half <= w_half_live;
      if (w_shift) begin
        r_sr    <= {(w_sym == SYM_ONE), r_sr[23:1]};
        r_count <= r_count + 5'd1;
        busy    <= 1'b1;
      end
      if (w_err || w_end_word) begin
        r_count <= '0;
        busy    <= 1'b0;
      end
      if (w_err) err_code <= w_err_code;
      if (w_valid) dat24 <= r_sr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arinc_recv.sv
`timescale 1ns/1ps
`default_nettype none
// =====================================================================
// tb_arinc_recv : directed stimulus with word/error scoreboard
// Rev 1.0
// =====================================================================
module tb_arinc_recv;

  localparam int HALF_H = 16;
  localparam int HALF_L = 40;
  localparam int GAP_HB = 4;
  localparam int FILT   = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RxA = 1'b0;
  logic        RxB = 1'b0;
  logic        recv_rate_sel = 1'b1;
  logic [23:0] dat24;
  logic        valid;
  logic        err;
  logic [1:0]  err_code;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [23:0] exp_q[$];
  logic [1:0]  err_q[$];

  always #5 clk = ~clk;

  arinc_recv #(
    .HALF_H (HALF_H),
    .HALF_L (HALF_L),
    .GAP_HB (GAP_HB),
    .FILT   (FILT),
    .CNT_W  (25)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .RxA           (RxA),
    .RxB           (RxB),
    .recv_rate_sel (recv_rate_sel),
    .dat24         (dat24),
    .valid         (valid),
    .err           (err),
    .err_code      (err_code),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic a, input logic b, input int cyc);
    RxA = a;
    RxB = b;
    repeat (cyc) @(negedge clk);
  endtask

  task automatic send_bits(input logic [23:0] w, input int lo, input int hi, input int half);
    for (int i = lo; i <= hi; i++) begin
      drive(w[i], ~w[i], half);
      drive(1'b0, 1'b0, half);
    end
  endtask

  // Full word; gap_halves counts the null that follows the last bit
  task automatic send_word(input logic [23:0] w, input int half, input int gap_halves);
    exp_q.push_back(w);
    send_bits(w, 0, 23, half);
    drive(1'b0, 1'b0, (gap_halves - 1) * half);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_words_pending"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_errs_pending"}, 32'(err_q.size()), 32'd0);
  endtask

  task automatic monitor_loop();
    logic [23:0] w;
    logic [1:0]  c;
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
        check("valid_without_err", 32'(err), 32'd0);
        check("valid_busy_low", 32'(busy), 32'd0);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check("dat24", 32'(dat24), 32'(w));
        end
      end
      if (rst_n && err) begin
        check("err_expected", 32'(err_q.size() != 0), 32'd1);
        check("err_without_valid", 32'(valid), 32'd0);
        check("err_busy_low", 32'(busy), 32'd0);
        if (err_q.size() != 0) begin
          c = err_q.pop_front();
          check("err_code", 32'(err_code), 32'(c));
        end
      end
    end
  endtask

  initial begin
    fork
      monitor_loop();
    join_none

    repeat (3) @(negedge clk);
    check("rst_dat24", 32'(dat24), 32'd0);
    check("rst_valid", 32'(valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 10 * HALF_H);

    // Single word at high rate
    exp_q.push_back(24'hA5C3F0);
    send_bits(24'hA5C3F0, 0, 0, HALF_H);
    check("t1_busy_mid_word", 32'(busy), 32'd1);
    send_bits(24'hA5C3F0, 1, 23, HALF_H);
    drive(1'b0, 1'b0, 9 * HALF_H);
    check_drained("t1");

    // Back-to-back words with the minimum transmitter gap
    send_word(24'h000001, HALF_H, 7);
    send_word(24'hFFFFFE, HALF_H, 10);
    check_drained("t2");

    // Low rate, rate select toggled mid-word
    recv_rate_sel = 1'b0;
    drive(1'b0, 1'b0, HALF_L);
    exp_q.push_back(24'h123456);
    send_bits(24'h123456, 0, 11, HALF_L);
    recv_rate_sel = 1'b1;
    send_bits(24'h123456, 12, 23, HALF_L);
    drive(1'b0, 1'b0, 9 * HALF_L);
    check_drained("t3");

    // Short word: 23 bits then gap
    err_q.push_back(2'b10);
    send_bits(24'h654321, 0, 22, HALF_H);
    drive(1'b0, 1'b0, 9 * HALF_H);
    check_drained("t4_err");
    send_word(24'h5A5A5A, HALF_H, 10);
    check_drained("t4_next");

    // Both lines high mid-word
    err_q.push_back(2'b01);
    send_bits(24'hC0FFEE, 0, 9, HALF_H);
    drive(1'b1, 1'b1, 20);
    drive(1'b0, 1'b0, 10 * HALF_H);
    check_drained("t5_err");
    send_word(24'h3C3C3C, HALF_H, 10);
    check_drained("t5_next");

    // Stretched data half-bit
    err_q.push_back(2'b11);
    send_bits(24'h00FF00, 0, 4, HALF_H);
    drive(1'b0, 1'b1, 3 * HALF_H);
    drive(1'b0, 1'b0, 10 * HALF_H);
    check_drained("t6_err");

    // Asynchronous reset mid-word, then the word tail must be ignored
    send_bits(24'h777777, 0, 4, HALF_H);
    drive(1'b1, 1'b0, 5);
    #2 rst_n = 1'b0;
    #1;
    check("arst_dat24", 32'(dat24), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_err", 32'(err), 32'd0);
    check("arst_err_code", 32'(err_code), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, HALF_H - 8);
    drive(1'b0, 1'b0, HALF_H);
    send_bits(24'h777777, 6, 23, HALF_H);
    drive(1'b0, 1'b0, 10 * HALF_H);
    check_drained("t7_tail");
    check("t7_busy_after_tail", 32'(busy), 32'd0);
    send_word(24'h0F1E2D, HALF_H, 10);
    check_drained("t7_next");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
